// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RISC-V control sequencer:
// FSM states, opcodes, ALU select/op codes and the control-word struct.
package riscv_ctrl_pkg;

    localparam logic [3:0] RST      = 4'd0;
    localparam logic [3:0] FETCH    = 4'd1;
    localparam logic [3:0] DECODE   = 4'd2;
    localparam logic [3:0] EXEC_R   = 4'd3;
    localparam logic [3:0] EXEC_I   = 4'd4;
    localparam logic [3:0] MEM_ADDR = 4'd5;
    localparam logic [3:0] MEM_RD   = 4'd6;
    localparam logic [3:0] MEM_WR   = 4'd7;
    localparam logic [3:0] WB_ALU   = 4'd8;
    localparam logic [3:0] WB_MEM   = 4'd9;
    localparam logic [3:0] BRANCH   = 4'd10;
    localparam logic [3:0] ILLEGAL  = 4'd11;
    localparam logic [3:0] BUS_ERR  = 4'd12;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_RTYPE = 2'b10;
    localparam logic [1:0] ALU_ITYPE = 2'b11;

    localparam logic       SRC_A_PC   = 1'b0;
    localparam logic       SRC_A_RS1  = 1'b1;
    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic       pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic       mem_to_reg;
        logic       illegal_instr;
        logic       bus_error;
    } ctrl_sig_t;

    // A store retires only once its write has actually been accepted.
    function automatic logic is_retiring(input logic [3:0] st, input logic mem_ready);
        logic ret;
        case (st)
            WB_ALU, WB_MEM, BRANCH: ret = 1'b1;
            MEM_WR:                 ret = mem_ready;
            default:                ret = 1'b0;
        endcase
        return ret;
    endfunction

    function automatic logic is_wait_state(input logic [3:0] st);
        logic w;
        case (st)
            FETCH, MEM_RD, MEM_WR: w = 1'b1;
            default:               w = 1'b0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts memory wait cycles; expired_o flags the last allowed wait cycle.
// MAX_WAIT of 0 removes the counter and never expires.
module mem_wait_timer #(
    parameter int MAX_WAIT = 16
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    generate
        if (MAX_WAIT > 0) begin : g_timer
            localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
            localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

            logic [CW-1:0] count_q;
            logic [CW-1:0] count_d;

            // Clear wins; the count parks at LAST rather than wrapping.
            always_comb begin
                count_d = count_q;
                if (clear_i) begin
                    count_d = '0;
                end else if (en_i && (count_q != LAST)) begin
                    count_d = count_q + CW'(1);
                end else begin
                    count_d = count_q;
                end
            end

            // Counter register.
            always_ff @(posedge clk_i or posedge reset_i) begin
                if (reset_i) begin
                    count_q <= '0;
                end else begin
                    count_q <= count_d;
                end
            end

            assign expired_o = (count_q == LAST);
        end else begin : g_no_timer
            assign expired_o = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/multicycle_control_fsm.sv
// Moore sequencer for the multi-cycle RISC-V datapath: steps each instruction
// through fetch/decode/execute/memory/writeback over one shared memory port.
module multicycle_control_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter int INSTRET_W = 32,
    parameter int MAX_WAIT  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           opcode,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 i_or_d,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 pc_src,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic                 reg_write,
    output logic                 mem_to_reg,
    output logic                 illegal_instr,
    output logic                 bus_error,
    output logic [INSTRET_W-1:0] instret,
    output logic [3:0]           state
);

    logic [3:0]           state_q;
    logic [3:0]           state_d;
    logic [INSTRET_W-1:0] instret_q;
    logic [INSTRET_W-1:0] instret_d;
    ctrl_sig_t            ctrl_s;
    logic                 wait_en_s;
    logic                 wait_clr_s;
    logic                 expired_s;

    // The timer runs only while a request is outstanding and unanswered.
    assign wait_en_s  = is_wait_state(state_q) & ~mem_ready;
    assign wait_clr_s = ~wait_en_s;

    mem_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk_i     (clk),
        .reset_i   (reset),
        .clear_i   (wait_clr_s),
        .en_i      (wait_en_s),
        .expired_o (expired_s)
    );

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RST:    state_d = FETCH;
            FETCH: begin
                if (mem_ready) begin
                    state_d = DECODE;
                end else if (expired_s) begin
                    state_d = BUS_ERR;
                end else begin
                    state_d = FETCH;
                end
            end
            DECODE: begin
                case (opcode)
                    OP_R:              state_d = EXEC_R;
                    OP_IALU:           state_d = EXEC_I;
                    OP_LOAD, OP_STORE: state_d = MEM_ADDR;
                    OP_BRANCH:         state_d = BRANCH;
                    default:           state_d = ILLEGAL;
                endcase
            end
            EXEC_R:   state_d = WB_ALU;
            EXEC_I:   state_d = WB_ALU;
            MEM_ADDR: begin
                if (opcode == OP_LOAD) begin
                    state_d = MEM_RD;
                end else begin
                    state_d = MEM_WR;
                end
            end
            MEM_RD: begin
                if (mem_ready) begin
                    state_d = WB_MEM;
                end else if (expired_s) begin
                    state_d = BUS_ERR;
                end else begin
                    state_d = MEM_RD;
                end
            end
            MEM_WR: begin
                if (mem_ready) begin
                    state_d = FETCH;
                end else if (expired_s) begin
                    state_d = BUS_ERR;
                end else begin
                    state_d = MEM_WR;
                end
            end
            WB_ALU:  state_d = FETCH;
            WB_MEM:  state_d = FETCH;
            BRANCH:  state_d = FETCH;
            ILLEGAL: state_d = FETCH;
            BUS_ERR: state_d = BUS_ERR;
            // Unused encodings restart the sequence cleanly.
            default: state_d = RST;
        endcase
    end

    // Moore control decode; FETCH and BRANCH also gate on an input.
    always_comb begin
        ctrl_s = '0;
        case (state_q)
            FETCH: begin
                ctrl_s.mem_read  = 1'b1;
                ctrl_s.i_or_d    = 1'b0;
                ctrl_s.alu_src_a = SRC_A_PC;
                ctrl_s.alu_src_b = SRC_B_FOUR;
                ctrl_s.alu_op    = ALU_ADD;
                ctrl_s.ir_write  = mem_ready;
                ctrl_s.pc_write  = mem_ready;
            end
            DECODE: begin
                ctrl_s.alu_src_a = SRC_A_PC;
                ctrl_s.alu_src_b = SRC_B_IMM;
                ctrl_s.alu_op    = ALU_ADD;
            end
            EXEC_R: begin
                ctrl_s.alu_src_a = SRC_A_RS1;
                ctrl_s.alu_src_b = SRC_B_RS2;
                ctrl_s.alu_op    = ALU_RTYPE;
            end
            EXEC_I: begin
                ctrl_s.alu_src_a = SRC_A_RS1;
                ctrl_s.alu_src_b = SRC_B_IMM;
                ctrl_s.alu_op    = ALU_ITYPE;
            end
            MEM_ADDR: begin
                ctrl_s.alu_src_a = SRC_A_RS1;
                ctrl_s.alu_src_b = SRC_B_IMM;
                ctrl_s.alu_op    = ALU_ADD;
            end
            MEM_RD: begin
                ctrl_s.mem_read = 1'b1;
                ctrl_s.i_or_d   = 1'b1;
            end
            MEM_WR: begin
                ctrl_s.mem_write = 1'b1;
                ctrl_s.i_or_d    = 1'b1;
            end
            WB_ALU: begin
                ctrl_s.reg_write  = 1'b1;
                ctrl_s.mem_to_reg = 1'b0;
            end
            WB_MEM: begin
                ctrl_s.reg_write  = 1'b1;
                ctrl_s.mem_to_reg = 1'b1;
            end
            BRANCH: begin
                ctrl_s.alu_src_a = SRC_A_RS1;
                ctrl_s.alu_src_b = SRC_B_RS2;
                ctrl_s.alu_op    = ALU_SUB;
                ctrl_s.pc_src    = 1'b1;
                ctrl_s.pc_write  = zero;
            end
            ILLEGAL: ctrl_s.illegal_instr = 1'b1;
            BUS_ERR: ctrl_s.bus_error     = 1'b1;
            default: ctrl_s = '0;
        endcase
    end

    // Retired-instruction count wraps silently.
    always_comb begin
        if (is_retiring(state_q, mem_ready)) begin
            instret_d = instret_q + INSTRET_W'(1);
        end else begin
            instret_d = instret_q;
        end
    end

    // State and counter registers; reset aborts any request at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= RST;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    assign mem_read      = ctrl_s.mem_read;
    assign mem_write     = ctrl_s.mem_write;
    assign i_or_d        = ctrl_s.i_or_d;
    assign ir_write      = ctrl_s.ir_write;
    assign pc_write      = ctrl_s.pc_write;
    assign pc_src        = ctrl_s.pc_src;
    assign alu_src_a     = ctrl_s.alu_src_a;
    assign alu_src_b     = ctrl_s.alu_src_b;
    assign alu_op        = ctrl_s.alu_op;
    assign reg_write     = ctrl_s.reg_write;
    assign mem_to_reg    = ctrl_s.mem_to_reg;
    assign illegal_instr = ctrl_s.illegal_instr;
    assign bus_error     = ctrl_s.bus_error;
    assign instret       = instret_q;
    assign state         = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm with MAX_WAIT=4, INSTRET_W=4 so the
// timeout boundary and counter wrap are reachable in a short run.
module tb_multicycle_control_fsm;

    localparam logic [3:0] T_RST = 4'd0, T_FETCH = 4'd1, T_DECODE = 4'd2, T_EXEC_R = 4'd3;
    localparam logic [3:0] T_EXEC_I = 4'd4, T_MEM_ADDR = 4'd5, T_MEM_RD = 4'd6, T_MEM_WR = 4'd7;
    localparam logic [3:0] T_WB_ALU = 4'd8, T_WB_MEM = 4'd9, T_BRANCH = 4'd10, T_ILLEGAL = 4'd11;
    localparam logic [3:0] T_BUS_ERR = 4'd12;

    localparam logic [6:0] C_R = 7'b0110011, C_LD = 7'b0000011, C_ST = 7'b0100011;
    localparam logic [6:0] C_BEQ = 7'b1100011, C_I = 7'b0010011, C_BAD = 7'b1111111;

    // {mem_read, mem_write, i_or_d, ir_write, pc_write, pc_src, alu_src_a,
    //  alu_src_b[1:0], alu_op[1:0], reg_write, mem_to_reg, illegal_instr, bus_error}
    localparam logic [14:0] O_NONE     = 15'b0_0_0_0_0_0_0_00_00_0_0_0_0;
    localparam logic [14:0] O_FETCH_RY = 15'b1_0_0_1_1_0_0_01_00_0_0_0_0;
    localparam logic [14:0] O_FETCH_WT = 15'b1_0_0_0_0_0_0_01_00_0_0_0_0;
    localparam logic [14:0] O_DECODE   = 15'b0_0_0_0_0_0_0_10_00_0_0_0_0;
    localparam logic [14:0] O_EXEC_R   = 15'b0_0_0_0_0_0_1_00_10_0_0_0_0;
    localparam logic [14:0] O_EXEC_I   = 15'b0_0_0_0_0_0_1_10_11_0_0_0_0;
    localparam logic [14:0] O_MEM_ADDR = 15'b0_0_0_0_0_0_1_10_00_0_0_0_0;
    localparam logic [14:0] O_MEM_RD   = 15'b1_0_1_0_0_0_0_00_00_0_0_0_0;
    localparam logic [14:0] O_MEM_WR   = 15'b0_1_1_0_0_0_0_00_00_0_0_0_0;
    localparam logic [14:0] O_WB_ALU   = 15'b0_0_0_0_0_0_0_00_00_1_0_0_0;
    localparam logic [14:0] O_WB_MEM   = 15'b0_0_0_0_0_0_0_00_00_1_1_0_0;
    localparam logic [14:0] O_BR_TAKEN = 15'b0_0_0_0_1_1_1_00_01_0_0_0_0;
    localparam logic [14:0] O_BR_NOT   = 15'b0_0_0_0_0_1_1_00_01_0_0_0_0;
    localparam logic [14:0] O_ILLEGAL  = 15'b0_0_0_0_0_0_0_00_00_0_0_1_0;
    localparam logic [14:0] O_BUS_ERR  = 15'b0_0_0_0_0_0_0_00_00_0_0_0_1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_read, mem_write, i_or_d, ir_write, pc_write, pc_src, alu_src_a;
    logic [1:0] alu_src_b, alu_op;
    logic       reg_write, mem_to_reg, illegal_instr, bus_error;
    logic [3:0] instret;
    logic [3:0] state;
    logic [14:0] outs;

    int checks = 0;
    int errors = 0;

    assign outs = {mem_read, mem_write, i_or_d, ir_write, pc_write, pc_src, alu_src_a,
                   alu_src_b, alu_op, reg_write, mem_to_reg, illegal_instr, bus_error};

    multicycle_control_fsm #(
        .INSTRET_W (4),
        .MAX_WAIT  (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .i_or_d        (i_or_d),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_src        (pc_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .reg_write     (reg_write),
        .mem_to_reg    (mem_to_reg),
        .illegal_instr (illegal_instr),
        .bus_error     (bus_error),
        .instret       (instret),
        .state         (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive inputs just after the falling edge, then sample 1 time unit later.
    task automatic cyc(input logic rdy, input logic [6:0] op, input logic z);
        @(negedge clk);
        mem_ready = rdy;
        opcode    = op;
        zero      = z;
        #1;
    endtask

    task automatic ck(input string tag, input logic [3:0] st, input logic [14:0] o);
        check({tag, "_state"}, {28'd0, state}, {28'd0, st});
        check({tag, "_outs"}, {17'd0, outs}, {17'd0, o});
    endtask

    initial begin
        #12;
        ck("reset", T_RST, O_NONE);
        check("reset_instret", {28'd0, instret}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        ck("rst_hold", T_RST, O_NONE);

        // R-type, zero wait states
        cyc(1'b1, C_R, 1'b0);  ck("r_fetch", T_FETCH, O_FETCH_RY);
        check("r_instret0", {28'd0, instret}, 32'd0);
        cyc(1'b1, C_R, 1'b0);  ck("r_decode", T_DECODE, O_DECODE);
        cyc(1'b1, C_R, 1'b0);  ck("r_exec", T_EXEC_R, O_EXEC_R);
        cyc(1'b1, C_R, 1'b0);  ck("r_wb", T_WB_ALU, O_WB_ALU);

        // Load, 3 wait states; completes on the last allowed wait cycle
        cyc(1'b1, C_LD, 1'b0); ck("ld_fetch", T_FETCH, O_FETCH_RY);
        check("r_instret1", {28'd0, instret}, 32'd1);
        cyc(1'b1, C_LD, 1'b0); ck("ld_decode", T_DECODE, O_DECODE);
        cyc(1'b1, C_LD, 1'b0); ck("ld_addr", T_MEM_ADDR, O_MEM_ADDR);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, C_LD, 1'b0); ck("ld_wait", T_MEM_RD, O_MEM_RD);
        end
        cyc(1'b1, C_LD, 1'b0); ck("ld_rd_done", T_MEM_RD, O_MEM_RD);
        cyc(1'b1, C_LD, 1'b0); ck("ld_wb", T_WB_MEM, O_WB_MEM);

        // Store
        cyc(1'b1, C_ST, 1'b0); ck("st_fetch", T_FETCH, O_FETCH_RY);
        check("ld_instret", {28'd0, instret}, 32'd2);
        cyc(1'b1, C_ST, 1'b0); ck("st_decode", T_DECODE, O_DECODE);
        cyc(1'b1, C_ST, 1'b0); ck("st_addr", T_MEM_ADDR, O_MEM_ADDR);
        cyc(1'b1, C_ST, 1'b0); ck("st_wr", T_MEM_WR, O_MEM_WR);

        // BEQ taken, then not taken
        cyc(1'b1, C_BEQ, 1'b1); ck("beq1_fetch", T_FETCH, O_FETCH_RY);
        check("st_instret", {28'd0, instret}, 32'd3);
        cyc(1'b1, C_BEQ, 1'b1); ck("beq1_decode", T_DECODE, O_DECODE);
        cyc(1'b1, C_BEQ, 1'b1); ck("beq1_taken", T_BRANCH, O_BR_TAKEN);
        cyc(1'b1, C_BEQ, 1'b0); ck("beq0_fetch", T_FETCH, O_FETCH_RY);
        check("beq1_instret", {28'd0, instret}, 32'd4);
        cyc(1'b1, C_BEQ, 1'b0); ck("beq0_decode", T_DECODE, O_DECODE);
        cyc(1'b1, C_BEQ, 1'b0); ck("beq0_not", T_BRANCH, O_BR_NOT);

        // I-ALU
        cyc(1'b1, C_I, 1'b0);  ck("i_fetch", T_FETCH, O_FETCH_RY);
        check("beq0_instret", {28'd0, instret}, 32'd5);
        cyc(1'b1, C_I, 1'b0);  ck("i_decode", T_DECODE, O_DECODE);
        cyc(1'b1, C_I, 1'b0);  ck("i_exec", T_EXEC_I, O_EXEC_I);
        cyc(1'b1, C_I, 1'b0);  ck("i_wb", T_WB_ALU, O_WB_ALU);

        // Illegal opcode: one-cycle pulse, not retired
        cyc(1'b1, C_BAD, 1'b0); ck("ill_fetch", T_FETCH, O_FETCH_RY);
        check("i_instret", {28'd0, instret}, 32'd6);
        cyc(1'b1, C_BAD, 1'b0); ck("ill_decode", T_DECODE, O_DECODE);
        cyc(1'b1, C_BAD, 1'b0); ck("ill_pulse", T_ILLEGAL, O_ILLEGAL);
        cyc(1'b1, C_R, 1'b0);   ck("ill_back", T_FETCH, O_FETCH_RY);
        check("ill_instret", {28'd0, instret}, 32'd6);

        // Ten more R-types: 4-bit counter runs 7..15 then wraps to 0
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, C_R, 1'b0);
            cyc(1'b1, C_R, 1'b0);
            cyc(1'b1, C_R, 1'b0);
            check("wrap_wb_state", {28'd0, state}, {28'd0, T_WB_ALU});
            cyc(1'b1, C_LD, 1'b0);
            check("wrap_instret", {28'd0, instret}, (7 + i) % 16);
        end
        check("wrap_zero", {28'd0, instret}, 32'd0);

        // Reset while a load read is outstanding
        cyc(1'b1, C_LD, 1'b0); ck("rr_decode", T_DECODE, O_DECODE);
        cyc(1'b1, C_LD, 1'b0); ck("rr_addr", T_MEM_ADDR, O_MEM_ADDR);
        cyc(1'b0, C_LD, 1'b0); ck("rr_rd", T_MEM_RD, O_MEM_RD);
        #2;
        reset = 1'b1;
        #1;
        ck("rr_abort", T_RST, O_NONE);
        check("rr_instret", {28'd0, instret}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        mem_ready = 1'b0;
        #1;
        ck("rr_rst_hold", T_RST, O_NONE);

        // FETCH with no response: BUS_ERR after 4 wait cycles
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, C_R, 1'b0); ck("to_fetch", T_FETCH, O_FETCH_WT);
        end
        cyc(1'b0, C_R, 1'b0); ck("to_buserr", T_BUS_ERR, O_BUS_ERR);
        cyc(1'b1, C_R, 1'b0); ck("to_sticky1", T_BUS_ERR, O_BUS_ERR);
        cyc(1'b1, C_R, 1'b0); ck("to_sticky2", T_BUS_ERR, O_BUS_ERR);
        @(negedge clk);
        reset = 1'b1;
        #1;
        ck("to_reset", T_RST, O_NONE);
        @(negedge clk);
        reset = 1'b0;
        cyc(1'b1, C_R, 1'b0); ck("to_restart", T_FETCH, O_FETCH_RY);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
